boundary_alignment_tracker: RTL and testbench

Consumes the per-boundary alignment stream (alignment in [0,1] Q14 plus detuning in OMEGA_DT units) produced by the f₀/f₁/f₂ boundary detectors and turns it into discrete alignment episodes. A hysteretic 4-state FSM with dwell qualification yields a locked flag, onset/release pulses, a duration for each completed episode, and an episode count. One instance sits downstream of each boundary detector and feeds the three-boundary coordination logic.

---
 rtl/boundary_alignment_tracker_pkg.sv | 27 ++
 rtl/boundary_alignment_tracker_sat_counter.sv | 37 +++
 rtl/boundary_alignment_tracker.sv | 249 ++++++++++++++++++++++++
 tb/tb_boundary_alignment_tracker.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/boundary_alignment_tracker_pkg.sv
// -----------------------------------------------------------------------------
// boundary_pkg
// Shared definitions for the boundary alignment tracker and the three-boundary
// coordination logic that consumes its state.
//   ONE_Q14         : unity in Q14 (1 << 14).
//   ON_THRESH_DEF   : default onset threshold (0.75 in Q14).
//   OFF_THRESH_DEF  : default release threshold (0.5 in Q14).
//   tracker_state_e : tracker FSM encoding (IDLE=0, ONSET=1, LOCKED=2, RELEASE=3).
// -----------------------------------------------------------------------------
package boundary_pkg;

  localparam int ONE_Q14        = 16384;
  localparam int ON_THRESH_DEF  = 12288;
  localparam int OFF_THRESH_DEF = 8192;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ONSET   = 2'd1,
    LOCKED  = 2'd2,
    RELEASE = 2'd3
  } tracker_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/boundary_alignment_tracker_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Priority: clr > load > inc.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (count -> 0)
//   clr       : synchronous clear to zero
//   load      : synchronous load of load_val
//   load_val  : value taken on load
//   inc       : increment by one unless already all-ones
//   count     : current count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc && !(&count)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/boundary_alignment_tracker.sv
// -----------------------------------------------------------------------------
// boundary_alignment_tracker
// Turns a per-boundary alignment/detuning sample stream into alignment
// episodes using a hysteretic IDLE/ONSET/LOCKED/RELEASE FSM with dwell
// qualification on both entry and exit.
//
// Optional feature macro: BOUNDARY_TRACKER_STATS_EN
//   defined   : peak_alignment / min_detuning track the current episode and
//               hold after release until the next onset.
//   undefined : tracking registers are absent, both outputs read 0.
//
// Handshake: there is no valid/ready pair; clk_en is a sample strobe. Each
// clk edge with clk_en=1 consumes exactly one (alignment_in, detuning_in)
// sample; with clk_en=0 the inputs are ignored and all state holds, except
// that pulses drop after one clk and clear_stats still acts.
//
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   clk_en            : sample strobe
//   alignment_in      : signed Q14 alignment (clamped to [0, ONE])
//   detuning_in       : signed detuning in OMEGA_DT units (negatives -> 0)
//   clear_stats       : synchronous clear of episode_count/episode_duration
//   locked            : high in LOCKED and RELEASE
//   onset_pulse       : one clk on ONSET -> LOCKED
//   release_pulse     : one clk on RELEASE -> IDLE
//   episode_duration  : enabled-sample length of last completed episode
//   episode_count     : completed episodes, saturating
//   peak_alignment    : max alignment of current/last episode
//   min_detuning      : min detuning of current/last episode
// The FSM state is visible as the internal signal 'state' (tracker_state_e).
// -----------------------------------------------------------------------------
module boundary_alignment_tracker
  import boundary_pkg::*;
#(
  parameter int WIDTH         = 18,
  parameter int FRAC          = 14,
  parameter int ON_THRESH     = ON_THRESH_DEF,
  parameter int OFF_THRESH    = OFF_THRESH_DEF,
  parameter int ONSET_DWELL   = 16,
  parameter int RELEASE_DWELL = 8,
  parameter int DUR_WIDTH     = 16,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  input  logic signed [WIDTH-1:0] alignment_in,
  input  logic signed [WIDTH-1:0] detuning_in,
  input  logic                    clear_stats,
  output logic                    locked,
  output logic                    onset_pulse,
  output logic                    release_pulse,
  output logic [DUR_WIDTH-1:0]    episode_duration,
  output logic [CNT_WIDTH-1:0]    episode_count,
  output logic signed [WIDTH-1:0] peak_alignment,
  output logic signed [WIDTH-1:0] min_detuning
);

  localparam logic signed [WIDTH-1:0] ONE_S = WIDTH'(2 ** FRAC);
  localparam logic signed [WIDTH-1:0] ON_S  = WIDTH'(ON_THRESH);
  localparam logic signed [WIDTH-1:0] OFF_S = WIDTH'(OFF_THRESH);

  // One dwell counter serves both ONSET and RELEASE; they never overlap.
  localparam int DW_W = $clog2(max_int(ONSET_DWELL, RELEASE_DWELL) + 1);
  localparam logic [DW_W:0] ONSET_DW_L   = (DW_W + 1)'(ONSET_DWELL);
  localparam logic [DW_W:0] RELEASE_DW_L = (DW_W + 1)'(RELEASE_DWELL);

  tracker_state_e state, state_next;

  logic signed [WIDTH-1:0] a;
  logic                    a_ge_on;
  logic                    a_lt_off;

  logic [DW_W-1:0]      dw;
  logic [DW_W:0]        dw_plus1;
  logic [DUR_WIDTH-1:0] dur;
  logic [DUR_WIDTH-1:0] dur_sat;

  logic dw_clr, dw_load, dw_inc;
  logic dur_clr, dur_inc;
  logic onset_evt, release_evt;

  // Input conditioning: clamp alignment to [0, ONE].
  always_comb begin
    a = alignment_in;
    if (alignment_in < 0) begin
      a = '0;
    end else if (alignment_in > ONE_S) begin
      a = ONE_S;
    end
  end

  assign a_ge_on  = (a >= ON_S);
  assign a_lt_off = (a < OFF_S);
  assign dw_plus1 = {1'b0, dw} + (DW_W + 1)'(1);
  // Length of the episode including the sample that completes the release.
  assign dur_sat  = (&dur) ? dur : dur + DUR_WIDTH'(1);

  // Next-state and counter control; nothing moves unless clk_en=1.
  always_comb begin
    state_next  = state;
    dw_clr      = 1'b0;
    dw_load     = 1'b0;
    dw_inc      = 1'b0;
    dur_clr     = 1'b0;
    dur_inc     = 1'b0;
    onset_evt   = 1'b0;
    release_evt = 1'b0;
    if (clk_en) begin
      case (state)
        IDLE: begin
          if (a_ge_on) begin
            if (ONSET_DWELL <= 1) begin
              onset_evt = 1'b1;
            end else begin
              state_next = ONSET;
              dw_load    = 1'b1;
            end
          end
        end
        ONSET: begin
          if (!a_ge_on) begin
            state_next = IDLE;
            dw_clr     = 1'b1;
          end else if (dw_plus1 >= ONSET_DW_L) begin
            onset_evt = 1'b1;
          end else begin
            dw_inc = 1'b1;
          end
        end
        LOCKED: begin
          dur_inc = 1'b1;
          if (a_lt_off) begin
            if (RELEASE_DWELL <= 1) begin
              release_evt = 1'b1;
            end else begin
              state_next = RELEASE;
              dw_load    = 1'b1;
            end
          end
        end
        RELEASE: begin
          dur_inc = 1'b1;
          if (!a_lt_off) begin
            state_next = LOCKED;
            dw_clr     = 1'b1;
          end else if (dw_plus1 >= RELEASE_DW_L) begin
            release_evt = 1'b1;
          end else begin
            dw_inc = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
      if (onset_evt) begin
        state_next = LOCKED;
        dw_clr     = 1'b1;
        dur_clr    = 1'b1;
      end
      if (release_evt) begin
        state_next = IDLE;
        dw_clr     = 1'b1;
      end
    end
  end

  sat_counter #(.W(DW_W)) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .clr      (dw_clr),
    .load     (dw_load),
    .load_val (DW_W'(1)),
    .inc      (dw_inc),
    .count    (dw)
  );

  sat_counter #(.W(DUR_WIDTH)) u_dur (
    .clk      (clk),
    .rst      (rst),
    .clr      (dur_clr),
    .load     (1'b0),
    .load_val ('0),
    .inc      (dur_inc),
    .count    (dur)
  );

  // clear_stats has priority, so a coinciding release still leaves count=0.
  sat_counter #(.W(CNT_WIDTH)) u_episodes (
    .clk      (clk),
    .rst      (rst),
    .clr      (clear_stats),
    .load     (1'b0),
    .load_val ('0),
    .inc      (release_evt),
    .count    (episode_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      locked           <= 1'b0;
      onset_pulse      <= 1'b0;
      release_pulse    <= 1'b0;
      episode_duration <= '0;
    end else begin
      state         <= state_next;
      locked        <= (state_next == LOCKED) || (state_next == RELEASE);
      // Events are only raised with clk_en=1, so pulses self-clear next edge.
      onset_pulse   <= onset_evt;
      release_pulse <= release_evt;
      if (clear_stats) begin
        episode_duration <= '0;
      end else if (release_evt) begin
        episode_duration <= dur_sat;
      end
    end
  end

`ifdef BOUNDARY_TRACKER_STATS_EN
  logic signed [WIDTH-1:0] d;
  logic signed [WIDTH-1:0] peak_r;
  logic signed [WIDTH-1:0] min_r;

  assign d = (detuning_in < 0) ? '0 : detuning_in;

  // Seeded on lock entry, tracked only while LOCKED, held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_r <= '0;
      min_r  <= '0;
    end else if (onset_evt) begin
      peak_r <= a;
      min_r  <= d;
    end else if (clk_en && (state == LOCKED)) begin
      if (a > peak_r) peak_r <= a;
      if (d < min_r)  min_r  <= d;
    end
  end

  assign peak_alignment = peak_r;
  assign min_detuning   = min_r;
`else
  logic unused_detuning;
  assign unused_detuning = ^detuning_in;
  assign peak_alignment  = '0;
  assign min_detuning    = '0;
`endif

endmodule

// File: tb/tb_boundary_alignment_tracker.sv
// -----------------------------------------------------------------------------
// tb_boundary_alignment_tracker
// Directed bench for boundary_alignment_tracker (default parameters:
// ON=12288, OFF=8192, ONSET_DWELL=16, RELEASE_DWELL=8). Each table row drives
// one input setting for 'reps' clk cycles (clk_en every cycle, 1-in-N, or
// off; clear_stats only on the last cycle) and then checks all outputs.
// Peak/min expectations apply when BOUNDARY_TRACKER_STATS_EN is defined,
// otherwise those outputs are expected to read 0.
// -----------------------------------------------------------------------------
module tb_boundary_alignment_tracker;

  localparam int NV = 29;

`ifdef BOUNDARY_TRACKER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // Clock / reset / DUT
  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               clk_en = 1'b0;
  logic signed [17:0] alignment_in = '0;
  logic signed [17:0] detuning_in = '0;
  logic               clear_stats = 1'b0;
  logic               locked;
  logic               onset_pulse;
  logic               release_pulse;
  logic [15:0]        episode_duration;
  logic [15:0]        episode_count;
  logic signed [17:0] peak_alignment;
  logic signed [17:0] min_detuning;

  always #5 clk = ~clk;

  boundary_alignment_tracker dut (
    .clk              (clk),
    .rst              (rst),
    .clk_en           (clk_en),
    .alignment_in     (alignment_in),
    .detuning_in      (detuning_in),
    .clear_stats      (clear_stats),
    .locked           (locked),
    .onset_pulse      (onset_pulse),
    .release_pulse    (release_pulse),
    .episode_duration (episode_duration),
    .episode_count    (episode_count),
    .peak_alignment   (peak_alignment),
    .min_detuning     (min_detuning)
  );

  typedef struct {
    int rst;
    int en;     // 0 = clk_en low, N = enabled on every Nth clk
    int align;
    int det;
    int clr;    // clear_stats on the last cycle of the row
    int reps;
    int e_lock;
    int e_on;
    int e_rel;
    int e_cnt;
    int e_dur;
    int e_peak;
    int e_min;
  } vec_t;

  vec_t vecs[NV];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(input int rst_v, input int en, input int align,
                              input int det, input int clr, input int reps,
                              input int e_lock, input int e_on, input int e_rel,
                              input int e_cnt, input int e_dur, input int e_peak,
                              input int e_min);
    vec_t v;
    v.rst = rst_v;   v.en = en;       v.align = align;  v.det = det;
    v.clr = clr;     v.reps = reps;   v.e_lock = e_lock; v.e_on = e_on;
    v.e_rel = e_rel; v.e_cnt = e_cnt; v.e_dur = e_dur;
    v.e_peak = e_peak; v.e_min = e_min;
    return v;
  endfunction

  // Scoreboard compare
  task automatic chk(input string name, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic check_all(input string tag, input vec_t v);
    chk({tag, " locked"},   int'(locked),           v.e_lock);
    chk({tag, " onset"},    int'(onset_pulse),      v.e_on);
    chk({tag, " release"},  int'(release_pulse),    v.e_rel);
    chk({tag, " count"},    int'(episode_count),    v.e_cnt);
    chk({tag, " duration"}, int'(episode_duration), v.e_dur);
    chk({tag, " peak"},     int'(peak_alignment),   STATS ? v.e_peak : 0);
    chk({tag, " min_det"},  int'(min_detuning),     STATS ? v.e_min : 0);
  endtask

  // Driver: inputs change on the falling edge, outputs checked 1 after rise.
  task automatic run_vec(input vec_t v, input int idx);
    for (int r = 0; r < v.reps; r++) begin
      @(negedge clk);
      rst          = (v.rst != 0);
      clk_en       = (v.en == 0) ? 1'b0 : ((r % v.en) == (v.en - 1));
      alignment_in = 18'(v.align);
      detuning_in  = 18'(v.det);
      clear_stats  = (r == v.reps - 1) ? (v.clr != 0) : 1'b0;
      @(posedge clk);
      #1;
    end
    check_all($sformatf("row%0d", idx), v);
  endtask

  initial begin
    //           rst en  align   det  clr reps  lk on rl cnt dur  peak   min
    vecs[0]  = mk(1, 1,      0,    0, 0,  2,   0, 0, 0, 0,  0,     0,    0);
    vecs[1]  = mk(0, 1,  16384,  300, 0, 15,   0, 0, 0, 0,  0,     0,    0);
    vecs[2]  = mk(0, 1,  16384,  300, 0,  1,   1, 1, 0, 0,  0, 16384,  300);
    vecs[3]  = mk(0, 1,  20000,  500, 0, 10,   1, 0, 0, 0,  0, 16384,  300);
    vecs[4]  = mk(0, 1,   4096,  100, 0,  7,   1, 0, 0, 0,  0, 16384,  100);
    vecs[5]  = mk(0, 1,  10000,  200, 0,  1,   1, 0, 0, 0,  0, 16384,  100);
    vecs[6]  = mk(0, 1,  10000,   50, 0, 22,   1, 0, 0, 0,  0, 16384,   50);
    vecs[7]  = mk(0, 1,   4096,   10, 0,  7,   1, 0, 0, 0,  0, 16384,   10);
    vecs[8]  = mk(0, 1,   4096,   10, 0,  1,   0, 0, 1, 1, 48, 16384,   10);
    vecs[9]  = mk(0, 1,      0,    0, 0,  1,   0, 0, 0, 1, 48, 16384,   10);
    vecs[10] = mk(0, 4,  12288,  700, 0, 60,   0, 0, 0, 1, 48, 16384,   10);
    vecs[11] = mk(0, 4,  12288,  700, 0,  4,   1, 1, 0, 1, 48, 12288,  700);
    vecs[12] = mk(0, 0,  12288,  700, 0,  1,   1, 0, 0, 1, 48, 12288,  700);
    vecs[13] = mk(0, 0,      0,    0, 0, 20,   1, 0, 0, 1, 48, 12288,  700);
    vecs[14] = mk(0, 1,  12288,  800, 0,  5,   1, 0, 0, 1, 48, 12288,  700);
    vecs[15] = mk(0, 1,      0,  900, 0,  7,   1, 0, 0, 1, 48, 12288,  700);
    vecs[16] = mk(0, 1,      0,  900, 1,  1,   0, 0, 1, 0,  0, 12288,  700);
    vecs[17] = mk(0, 1,      0,  900, 0,  1,   0, 0, 0, 0,  0, 12288,  700);
    vecs[18] = mk(0, 1,  -5000, -300, 0, 20,   0, 0, 0, 0,  0, 12288,  700);
    vecs[19] = mk(0, 1,  16384,  -40, 0, 16,   1, 1, 0, 0,  0, 16384,    0);
    vecs[20] = mk(0, 1,  16384,  -40, 0,  3,   1, 0, 0, 0,  0, 16384,    0);
    vecs[21] = mk(1, 1,  16384,    0, 0,  1,   0, 0, 0, 0,  0,     0,    0);
    vecs[22] = mk(0, 1,      0,    0, 0, 10,   0, 0, 0, 0,  0,     0,    0);
    vecs[23] = mk(0, 1,  16384,    5, 0, 16,   1, 1, 0, 0,  0, 16384,    5);
    vecs[24] = mk(0, 1,   8191,    5, 0,  8,   0, 0, 1, 1,  8, 16384,    5);
    vecs[25] = mk(0, 0,      0,    0, 1,  1,   0, 0, 0, 0,  0, 16384,    5);
    vecs[26] = mk(0, 1,  12287,    3, 0, 20,   0, 0, 0, 0,  0, 16384,    5);
    vecs[27] = mk(0, 1,  12288,    0, 0, 16,   1, 1, 0, 0,  0, 12288,    0);
    vecs[28] = mk(0, 1,   8192,    0, 0, 30,   1, 0, 0, 0,  0, 12288,    0);

    for (int i = 0; i < NV; i++) begin
      run_vec(vecs[i], i);
    end

    // clear_stats while LOCKED must leave the FSM alone; the release that
    // follows is then counted from zero. Episode: 30 + 1 + 8 samples = 39.
    @(negedge clk);
    clk_en = 1'b1; alignment_in = 18'sd12288; detuning_in = '0; clear_stats = 1'b1;
    @(posedge clk);
    #1;
    chk("clr_locked locked", int'(locked), 1);
    chk("clr_locked count", int'(episode_count), 0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      clear_stats = 1'b0; alignment_in = '0;
      @(posedge clk);
      #1;
      chk($sformatf("tail%0d release", k), int'(release_pulse), (k == 8) ? 1 : 0);
      chk($sformatf("tail%0d locked", k), int'(locked), (k == 8) ? 0 : 1);
    end
    chk("tail count", int'(episode_count), 1);
    chk("tail duration", int'(episode_duration), 39);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
